trg_event_recorder: RTL and testbench
=====================================

// Module: trg_event_recorder
// PURPOSE
//  Sits directly downstream of the trigger generator in the CLK_42MHZ domain. Watches issued TRG pulses and returning ACK lines.
//  For each trigger it builds one 32-bit record: timestamp, which SCRODs acknowledged, and how many.
//  Records are queued in a show-ahead FIFO that the wishbone slave drains; this gives software per-event ACK history.
// PARAMETERS
//  ADDR_W      4   FIFO address width; DEPTH = 2**ADDR_W records
//  ACK_WINDOW  32  cycles ACK is collected after a trigger, legal range 1..255
// PORTS
//  CLK_42MHZ   in   1         sole clock; all logic on rising edge
//  RESET_N     in   1         asynchronous, active-low reset
//  TRG         in   12        per-SCROD trigger lines as driven by the trigger generator
//  ACK         in   12        per-SCROD acknowledge lines
//  TRG_MASK    in   12        1 = SCROD enabled; masked bits ignored for TRG and ACK
//  EN          in   1         1 = new triggers may start a record
//  TS_CLR      in   1         synchronous timestamp clear
//  RD_REQ      in   1         pop head record (one pop per high cycle)
//  OVF_CLR     in   1         clears OVERFLOW and MISSED
//  RD_DATA     out  32        head record; valid while RD_VALID=1
//  RD_VALID    out  1         FIFO non-empty
//  FIFO_COUNT  out  ADDR_W+1  records stored, 0..DEPTH
//  OVERFLOW    out  1         sticky: a record was dropped because FIFO full
//  MISSED      out  8         saturating count of triggers ignored while busy
// BEHAVIOUR
//  Reset (RESET_N=0): state IDLE, TS=0, FIFO empty, RD_VALID=0, RD_DATA=0, FIFO_COUNT=0, OVERFLOW=0, MISSED=0.
//  Timestamp: 16-bit free-running, +1 per cycle, wraps 0xFFFF->0x0000.
//   TS_CLR=1 forces TS=0 on next edge; TS then increments normally.
//  Trigger detect: hit = |((TRG & TRG_MASK) & ~TRG_q), where TRG_q is TRG registered once (rising edge of any enabled line).
//  FSM:
//   IDLE: on hit && EN: capture TS into ts_cap, ack_acc <= ACK & TRG_MASK, win <= 1, go COLLECT.
//    hit with EN=0 is ignored silently; it does not count toward MISSED.
//   COLLECT: ack_acc |= ACK & TRG_MASK each cycle; win++.
//    When win == ACK_WINDOW, go WRITE (ACK sampled on exactly ACK_WINDOW cycles, detect cycle included).
//   WRITE: push {ts_cap[15:0], popcount(ack_acc)[3:0], ack_acc[11:0]}; go IDLE.
//    A hit on the IDLE cycle that follows is accepted.
//  Any hit seen in COLLECT or WRITE: MISSED++, saturating at 0xFF.
//  EN falling mid-record: the record still completes and is written.
//  TRG_MASK change mid-record: the new mask applies from that cycle on.
//  FIFO (show-ahead): RD_DATA = head entry, registered; RD_DATA=0 when empty.
//   RD_REQ && RD_VALID pops; the next entry appears the following cycle.
//   RD_REQ when empty: ignored, no underflow.
//   Push when FIFO_COUNT==DEPTH and no pop this cycle: record dropped, OVERFLOW<=1.
//   Simultaneous push+pop when full: both occur, count stays DEPTH, no overflow.
//   Simultaneous push+pop when empty: push only.
//   Pointers wrap modulo DEPTH; FIFO_COUNT is updated on the same edge as the push/pop.
//  OVF_CLR=1: OVERFLOW<=0, MISSED<=0. An overflow or miss in the same cycle wins (sets 1 / count 1).
//  Reset asserted mid-record or mid-read: everything returns to reset values immediately, and the partial record is lost.
// TESTING
//  T1:  ACK_WINDOW=32, mask 0xFFF. TS_CLR, then TRG[3] pulse at TS=0x0010; ACK[3] at +5, ACK[7] at +31
//       -> one record 0x0010_2088.
//  T2:  ACK[5] at +32 after the trigger -> outside window; record ack field 0x000, count 0.
//  T3:  Fill 16 records without reads, then 17th trigger -> FIFO_COUNT=16, OVERFLOW=1, first 16 records intact in order.
//  T4:  FIFO full; pop timed on the WRITE cycle -> FIFO_COUNT stays 16, OVERFLOW stays 0.
//  T5:  Second TRG pulse 10 cycles after the first -> MISSED=1, one record.
//       TRG pulse on a masked bit (TRG_MASK[2]=0) -> no record.
//       EN=0 -> no record, MISSED unchanged.
//  T6:  Hold TS to wrap: trigger at TS=0xFFFF -> record [31:16]=0xFFFF.
//       Assert RESET_N low mid-COLLECT -> FIFO_COUNT=0, no record written after release.

Source files
------------

// File: rtl/trg_event_recorder.sv
// Per-trigger ACK recorder: builds {timestamp, ack count, ack mask} records
// and queues them in a show-ahead FIFO for the wishbone slave to drain.
module trg_event_recorder #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned ACK_WINDOW = 32
) (
  input  logic              CLK_42MHZ,
  input  logic              RESET_N,
  input  logic [11:0]       TRG,
  input  logic [11:0]       ACK,
  input  logic [11:0]       TRG_MASK,
  input  logic              EN,
  input  logic              TS_CLR,
  input  logic              RD_REQ,
  input  logic              OVF_CLR,
  output logic [31:0]       RD_DATA,
  output logic              RD_VALID,
  output logic [ADDR_W:0]   FIFO_COUNT,
  output logic              OVERFLOW,
  output logic [7:0]        MISSED
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [15:0]         ts;
  logic [11:0]         trg_q;
  logic                hit;
  logic [15:0]         ts_cap;
  logic [11:0]         ack_acc;
  logic [7:0]          win;
  logic                start_rec, collect_en, push, miss_inc;
  logic [31:0]         push_data;

  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic                pop, full, wr_en, drop;
  logic [CNT_W-1:0]    count_n;
  logic [31:0]         head_n;

  // Rising edge of any enabled trigger line
  always_comb hit = |((TRG & TRG_MASK) & ~trg_q);

  // Free-running timestamp and trigger history
  always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      ts    <= '0;
      trg_q <= '0;
    end else begin
      ts    <= TS_CLR ? 16'd0 : ts + 16'd1;
      trg_q <= TRG;
    end
  end

  // FSM state register
  always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_n;
  end

  // FSM next state and control strobes; the detect cycle is the first ACK sample
  always_comb begin
    state_n    = state;
    start_rec  = 1'b0;
    collect_en = 1'b0;
    push       = 1'b0;
    miss_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit && EN) begin
          start_rec = 1'b1;
          state_n   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        miss_inc = hit;
        if (win == 8'(ACK_WINDOW)) state_n = ST_WRITE;
        else                       collect_en = 1'b1;
      end
      ST_WRITE: begin
        miss_inc = hit;
        push     = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Record capture and ACK accumulation
  always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_cap  <= '0;
      ack_acc <= '0;
      win     <= '0;
    end else if (start_rec) begin
      ts_cap  <= ts;
      ack_acc <= ACK & TRG_MASK;
      win     <= 8'd1;
    end else if (collect_en) begin
      ack_acc <= ack_acc | (ACK & TRG_MASK);
      win     <= win + 8'd1;
    end
  end

  always_comb push_data = {ts_cap, 4'($countones(ack_acc)), ack_acc};

  // FIFO control and next registered head (show-ahead)
  always_comb begin
    pop   = RD_REQ && (FIFO_COUNT != '0);
    full  = (FIFO_COUNT == CNT_W'(DEPTH));
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
    case ({wr_en, pop})
      2'b10:   count_n = FIFO_COUNT + CNT_W'(1);
      2'b01:   count_n = FIFO_COUNT - CNT_W'(1);
      default: count_n = FIFO_COUNT;
    endcase
    if (count_n == '0)                head_n = '0;
    else if (pop)                     head_n = (FIFO_COUNT == CNT_W'(1)) ? push_data
                                               : mem[rd_ptr + ADDR_W'(1)];
    else if (FIFO_COUNT == '0)        head_n = push_data;
    else                              head_n = RD_DATA;
  end

  // Record storage
  always_ff @(posedge CLK_42MHZ) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, count and registered head
  always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_COUNT <= '0;
      RD_VALID   <= 1'b0;
      RD_DATA    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
      FIFO_COUNT <= count_n;
      RD_VALID   <= (count_n != '0);
      RD_DATA    <= head_n;
    end
  end

  // Sticky overflow and saturating missed-trigger count; new events beat clear
  always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      OVERFLOW <= 1'b0;
      MISSED   <= '0;
    end else begin
      if (drop)         OVERFLOW <= 1'b1;
      else if (OVF_CLR) OVERFLOW <= 1'b0;
      if (OVF_CLR)                          MISSED <= miss_inc ? 8'd1 : 8'd0;
      else if (miss_inc && MISSED != 8'hFF) MISSED <= MISSED + 8'd1;
    end
  end

endmodule

// File: tb/tb_trg_event_recorder.sv
// Bench for trg_event_recorder: event-level model plus directed scenarios.
module tb_trg_event_recorder;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] trg = '0, ack = '0, mask = 12'hFFF;
  logic        en = 1'b1, ts_clr = 1'b0, rd_req = 1'b0, ovf_clr = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid, overflow;
  logic [4:0]  fifo_count;
  logic [7:0]  missed;

  int total = 0;
  int bad   = 0;

  trg_event_recorder #(.ADDR_W(4), .ACK_WINDOW(W)) dut (
    .CLK_42MHZ (clk),
    .RESET_N   (rst_n),
    .TRG       (trg),
    .ACK       (ack),
    .TRG_MASK  (mask),
    .EN        (en),
    .TS_CLR    (ts_clr),
    .RD_REQ    (rd_req),
    .OVF_CLR   (ovf_clr),
    .RD_DATA   (rd_data),
    .RD_VALID  (rd_valid),
    .FIFO_COUNT(fifo_count),
    .OVERFLOW  (overflow),
    .MISSED    (missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Event-level model: a record opens on an accepted edge, samples ACK for
  // window offsets 0..W-1, is queued at offset W+1; new edges inside that span are misses.
  int unsigned  m_ts;
  logic [11:0]  m_prev;
  bit           m_open;
  int           m_age;
  logic [11:0]  m_acc;
  logic [15:0]  m_tscap;
  logic [31:0]  m_q[$];
  bit           m_ovf;
  int           m_missed;

  task automatic model_step();
    bit h, miss, push, pop, ovf_set;
    logic [31:0] rec;
    if (!rst_n) begin
      m_ts = 0; m_prev = '0; m_open = 0; m_age = 0; m_acc = '0;
      m_tscap = '0; m_q.delete(); m_ovf = 0; m_missed = 0;
      return;
    end
    h = |((trg & mask) & ~m_prev);
    miss = 0; push = 0; ovf_set = 0; rec = '0;
    if (m_open) begin
      m_age++;
      if (m_age < int'(W)) m_acc |= ack & mask;
      miss = h;
      if (m_age == int'(W) + 1) begin
        rec = {m_tscap, 4'($countones(m_acc)), m_acc};
        push = 1;
        m_open = 0;
      end
    end else if (h && en) begin
      m_open = 1; m_age = 0; m_acc = ack & mask; m_tscap = 16'(m_ts);
    end
    pop = rd_req && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(rec);
      else ovf_set = 1;
    end
    if (ovf_set)      m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (ovf_clr)                     m_missed = miss ? 1 : 0;
    else if (miss && m_missed < 255) m_missed++;
    m_ts = ts_clr ? 0 : ((m_ts + 1) & 32'hFFFF);
    m_prev = trg;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(posedge clk);
    #1;
    chk("rd_data",    rd_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
    chk("rd_valid",   32'(rd_valid), 32'(m_q.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow",   32'(overflow), 32'(m_ovf));
    chk("missed",     32'(missed), 32'(m_missed));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One trigger pulse at offset 0, two optional ACK pulses, optional pop cycle
  task automatic trig_run(input logic [11:0] t, input int o1, input logic [11:0] a1,
                          input int o2, input logic [11:0] a2, input int rd_off, input int len);
    for (int k = 0; k < len; k++) begin
      trg    = (k == 0) ? t : 12'h000;
      ack    = ((k == o1) ? a1 : 12'h000) | ((k == o2) ? a2 : 12'h000);
      rd_req = (k == rd_off);
      @(negedge clk);
    end
    trg = '0; ack = '0; rd_req = 1'b0;
  endtask

  task automatic pop_one();
    trig_run(12'h000, -1, 12'h000, -1, 12'h000, 0, 2);
  endtask

  initial begin
    tick(2);
    chk("reset_rd_valid",   32'(rd_valid), 32'h0);
    chk("reset_fifo_count", 32'(fifo_count), 32'h0);
    chk("reset_rd_data",    rd_data, 32'h0);
    chk("reset_overflow",   32'(overflow), 32'h0);
    chk("reset_missed",     32'(missed), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // T1: trigger at TS=0x0010 with ACK[3] at +5 and ACK[7] at +31
    ts_clr = 1'b1; tick(1); ts_clr = 1'b0; tick(16);
    trig_run(12'h008, 5, 12'h008, 31, 12'h080, -1, 40);
    chk("t1_record", rd_data, 32'h0010_2088);
    chk("t1_count",  32'(fifo_count), 32'h1);
    pop_one();

    // T2: ACK at +32 lands outside the window
    trig_run(12'h001, 32, 12'h020, -1, 12'h000, -1, 40);
    chk("t2_ack_field", {16'h0, rd_data[15:0]}, 32'h0);
    chk("t2_count",     32'(fifo_count), 32'h1);
    pop_one();

    // T3: back-to-back records (next edge on the cycle right after the write), 17th overflows
    for (int i = 0; i < 17; i++)
      trig_run(12'(1 << (i % 12)), i, 12'(1 << ((i + 1) % 12)), -1, 12'h000, -1, 34);
    tick(5);
    chk("t3_count",    32'(fifo_count), 32'd16);
    chk("t3_overflow", 32'(overflow), 32'h1);

    // T4: full FIFO, pop coincides with the write cycle
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("t4_ovf_cleared", 32'(overflow), 32'h0);
    trig_run(12'h010, 0, 12'h010, -1, 12'h000, 33, 40);
    chk("t4_count",    32'(fifo_count), 32'd16);
    chk("t4_overflow", 32'(overflow), 32'h0);
    rd_req = 1'b1; tick(20); rd_req = 1'b0;
    tick(1);
    chk("t4_drained", 32'(fifo_count), 32'h0);
    chk("t4_rd_data", rd_data, 32'h0);

    // T5: second trigger while busy is a miss; masked line and EN=0 make no record
    trig_run(12'h002, -1, 12'h000, -1, 12'h000, -1, 10);
    trig_run(12'h004, -1, 12'h000, -1, 12'h000, -1, 30);
    chk("t5_missed", 32'(missed), 32'h1);
    chk("t5_count",  32'(fifo_count), 32'h1);
    pop_one();
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    mask = 12'hFFB;
    trig_run(12'h004, -1, 12'h000, -1, 12'h000, -1, 40);
    chk("t5_masked", 32'(fifo_count), 32'h0);
    mask = 12'hFFF; en = 1'b0;
    trig_run(12'h001, -1, 12'h000, -1, 12'h000, -1, 40);
    chk("t5_en_off_count",  32'(fifo_count), 32'h0);
    chk("t5_en_off_missed", 32'(missed), 32'h0);
    en = 1'b1;
    // EN drops and mask narrows mid-record; record still completes
    trig_run(12'h001, 2, 12'h003, -1, 12'h000, -1, 5);
    en = 1'b0; mask = 12'hFFE;
    trig_run(12'h000, 3, 12'h005, -1, 12'h000, -1, 40);
    en = 1'b1; mask = 12'hFFF;
    chk("t5_en_fall_count", 32'(fifo_count), 32'h1);
    chk("t5_en_fall_acks",  {16'h0, rd_data[15:0]}, 32'h0000_3007);
    pop_one();

    // T6: trigger at TS=0xFFFF, then reset mid-record
    ts_clr = 1'b1; tick(1); ts_clr = 1'b0; tick(65535);
    trig_run(12'h800, 0, 12'h800, -1, 12'h000, -1, 40);
    chk("t6_ts_wrap", rd_data, 32'hFFFF_1800);
    pop_one();
    trig_run(12'h001, 1, 12'h001, -1, 12'h000, -1, 10);
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    tick(40);
    chk("t6_reset_count", 32'(fifo_count), 32'h0);
    chk("t6_reset_valid", 32'(rd_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
